// File: rtl/shadow_ram_ctrl_if.sv
// Bundle of the render read port and the host write/commit port of shadow_ram_ctrl.
// The master side is driven by the render stage and the host; the slave side is the controller.
// Ports:
//   rd_addr_i/rd_data_o          render read port
//   vsync_i                      frame sync
//   wr_valid_i/wr_ready_o/wr_addr_i/wr_data_i
//                                host write port
//   commit_i/busy_o/frame_swap_o commit handshake and status
interface shadow_ram_ctrl_if;
  logic [3:0] rd_addr_i;
  logic [4:0] rd_data_o;
  logic       vsync_i;
  logic       wr_valid_i;
  logic       wr_ready_o;
  logic [3:0] wr_addr_i;
  logic [4:0] wr_data_i;
  logic       commit_i;
  logic       busy_o;
  logic       frame_swap_o;

  modport master (
    output rd_addr_i, vsync_i, wr_valid_i, wr_addr_i, wr_data_i, commit_i,
    input  rd_data_o, wr_ready_o, busy_o, frame_swap_o
  );

  modport slave (
    input  rd_addr_i, vsync_i, wr_valid_i, wr_addr_i, wr_data_i, commit_i,
    output rd_data_o, wr_ready_o, busy_o, frame_swap_o
  );
endinterface

// File: rtl/shadow_ram_ctrl.sv
// Frame-synchronous 16 x 5-bit shadow RAM: host edits a back bank, banks swap on vsync rise.
// Latency: read data registered, 1 cycle; swap 1 cycle after vsync_i rises; copy-back 16 cycles.
// Backpressure: wr_ready_o low while a commit is pending or the copy-back runs.
// Ports: render_clk_i/render_rst_i (async, active-high) plus bus (shadow_ram_ctrl_if.slave).
// Build option SHADOW_RAM_DBUF_EN: defined = dual bank with copy-back;
// undefined = single bank, writes land directly in the table being read.
module shadow_ram_ctrl (
  input  logic             render_clk_i,
  input  logic             render_rst_i,
  shadow_ram_ctrl_if.slave bus
);

  logic       vsync_q;
  logic       vsync_edge;
  logic [4:0] rd_data_q, rd_data_d;
  logic       frame_swap_q, frame_swap_d;

  assign vsync_edge       = bus.vsync_i & ~vsync_q;
  assign bus.rd_data_o    = rd_data_q;
  assign bus.frame_swap_o = frame_swap_q;

`ifdef SHADOW_RAM_DBUF_EN

  typedef enum logic [1:0] {IDLE, PENDING, COPY} state_t;

  state_t           state_q, state_d;
  logic             front_sel_q, front_sel_d;
  logic [3:0]       idx_q, idx_d;
  logic [15:0][4:0] bank0_q, bank0_d;
  logic [15:0][4:0] bank1_q, bank1_d;
  logic             wr_ready;
  logic             wr_fire;

  assign wr_ready       = (state_q == IDLE);
  assign wr_fire        = bus.wr_valid_i & wr_ready;
  assign bus.wr_ready_o = wr_ready;
  assign bus.busy_o     = (state_q != IDLE);

  // front_sel_q is still the old value on the swap edge, so that read sees the old table.
  assign rd_data_d = front_sel_q ? bank1_q[bus.rd_addr_i] : bank0_q[bus.rd_addr_i];

  always_comb begin
    state_d      = state_q;
    front_sel_d  = front_sel_q;
    idx_d        = idx_q;
    bank0_d      = bank0_q;
    bank1_d      = bank1_q;
    frame_swap_d = 1'b0;
    case (state_q)
      IDLE: begin
        // Host writes only ever target the back bank.
        if (wr_fire) begin
          if (front_sel_q) bank0_d[bus.wr_addr_i] = bus.wr_data_i;
          else             bank1_d[bus.wr_addr_i] = bus.wr_data_i;
        end
        if (bus.commit_i) state_d = PENDING;
      end
      PENDING: begin
        if (vsync_edge) begin
          front_sel_d  = ~front_sel_q;
          idx_d        = 4'd0;
          frame_swap_d = 1'b1;
          state_d      = COPY;
        end
      end
      COPY: begin
        // Refresh the new back bank from the new front so host edits start from what is shown.
        if (front_sel_q) bank0_d[idx_q] = bank1_q[idx_q];
        else             bank1_d[idx_q] = bank0_q[idx_q];
        idx_d = idx_q + 4'd1;
        if (idx_q == 4'd15) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge render_clk_i or posedge render_rst_i) begin
    if (render_rst_i) begin
      state_q     <= IDLE;
      front_sel_q <= 1'b0;
      idx_q       <= 4'd0;
      bank0_q     <= '0;
      bank1_q     <= '0;
    end else begin
      state_q     <= state_d;
      front_sel_q <= front_sel_d;
      idx_q       <= idx_d;
      bank0_q     <= bank0_d;
      bank1_q     <= bank1_d;
    end
  end

`else

  logic [15:0][4:0] bank_q, bank_d;
  logic             pending_q, pending_d;

  assign bus.wr_ready_o = 1'b1;
  assign bus.busy_o     = pending_q;
  assign rd_data_d      = bank_q[bus.rd_addr_i];

  always_comb begin
    bank_d       = bank_q;
    pending_d    = pending_q;
    frame_swap_d = 1'b0;
    if (bus.wr_valid_i) bank_d[bus.wr_addr_i] = bus.wr_data_i;
    // The frame boundary only acknowledges the commit; no data moves.
    if (pending_q && vsync_edge) begin
      pending_d    = 1'b0;
      frame_swap_d = 1'b1;
    end else if (bus.commit_i) begin
      pending_d = 1'b1;
    end
  end

  always_ff @(posedge render_clk_i or posedge render_rst_i) begin
    if (render_rst_i) begin
      bank_q    <= '0;
      pending_q <= 1'b0;
    end else begin
      bank_q    <= bank_d;
      pending_q <= pending_d;
    end
  end

`endif

  always_ff @(posedge render_clk_i or posedge render_rst_i) begin
    if (render_rst_i) begin
      vsync_q      <= 1'b0;
      rd_data_q    <= 5'd0;
      frame_swap_q <= 1'b0;
    end else begin
      vsync_q      <= bus.vsync_i;
      rd_data_q    <= rd_data_d;
      frame_swap_q <= frame_swap_d;
    end
  end

endmodule

// File: tb/tb_shadow_ram_ctrl.sv
// Self-checking bench for shadow_ram_ctrl: directed scenarios plus random traffic,
// compared every cycle against a table-level model (shown table, staged table, block window).
// Works for both builds; SHADOW_RAM_DBUF_EN selects the matching model rules.
module tb_shadow_ram_ctrl;

`ifdef SHADOW_RAM_DBUF_EN
  localparam bit DBUF     = 1'b1;
  localparam int COPY_CYC = 16;
`else
  localparam bit DBUF     = 1'b0;
  localparam int COPY_CYC = 0;
`endif

  logic clk = 1'b0;
  logic rst = 1'b1;

  shadow_ram_ctrl_if bus ();

  shadow_ram_ctrl u_dut (
    .render_clk_i (clk),
    .render_rst_i (rst),
    .bus          (bus)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  // Model: shown[] is what the render stage reads, staged[] what the host has edited.
  int shown  [16];
  int staged [16];
  bit m_pend;
  int m_block;
  bit m_vprev;

  task automatic chk(input string tag, input int obs, input int exp);
    n_checks++;
    if (obs != exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic model_clear();
    for (int i = 0; i < 16; i++) begin
      shown[i]  = 0;
      staged[i] = 0;
    end
    m_pend  = 1'b0;
    m_block = 0;
    m_vprev = 1'b0;
  endtask

  task automatic idle_inputs();
    bus.rd_addr_i  = 4'd0;
    bus.vsync_i    = 1'b0;
    bus.wr_valid_i = 1'b0;
    bus.wr_addr_i  = 4'd0;
    bus.wr_data_i  = 5'd0;
    bus.commit_i   = 1'b0;
  endtask

  // Advance one clock: predict from the inputs being applied, then compare all outputs.
  task automatic step();
    bit ready, edge_det, exp_swap, exp_ready, exp_busy;
    int exp_rd;
    ready    = DBUF ? (!m_pend && m_block == 0) : 1'b1;
    exp_rd   = shown[bus.rd_addr_i];
    edge_det = bus.vsync_i && !m_vprev;
    exp_swap = m_pend && edge_det;
    if (ready && bus.wr_valid_i) begin
      if (DBUF) staged[bus.wr_addr_i] = int'(bus.wr_data_i);
      else      shown[bus.wr_addr_i]  = int'(bus.wr_data_i);
    end
    if (m_block > 0) m_block--;
    if (m_pend && edge_det) begin
      m_pend = 1'b0;
      if (DBUF) begin
        shown   = staged;
        m_block = COPY_CYC;
      end
    end else if (bus.commit_i && !m_pend && m_block == 0) begin
      m_pend = 1'b1;
    end
    m_vprev   = bus.vsync_i;
    exp_ready = DBUF ? (!m_pend && m_block == 0) : 1'b1;
    exp_busy  = m_pend || (m_block > 0);
    @(posedge clk);
    #1;
    chk("rd_data", int'(bus.rd_data_o), exp_rd);
    chk("frame_swap", int'(bus.frame_swap_o), int'(exp_swap));
    chk("wr_ready", int'(bus.wr_ready_o), int'(exp_ready));
    chk("busy", int'(bus.busy_o), int'(exp_busy));
  endtask

  task automatic do_reset();
    idle_inputs();
    rst = 1'b1;
    model_clear();
    repeat (2) @(posedge clk);
    #1;
    chk("rst_rd_data", int'(bus.rd_data_o), 0);
    chk("rst_wr_ready", int'(bus.wr_ready_o), 1);
    chk("rst_busy", int'(bus.busy_o), 0);
    chk("rst_frame_swap", int'(bus.frame_swap_o), 0);
    rst = 1'b0;
  endtask

  task automatic write(input int a, input int d, input bit with_commit);
    bus.wr_valid_i = 1'b1;
    bus.wr_addr_i  = 4'(a);
    bus.wr_data_i  = 5'(d);
    bus.commit_i   = with_commit;
    step();
    bus.wr_valid_i = 1'b0;
    bus.commit_i   = 1'b0;
  endtask

  task automatic commit();
    bus.commit_i = 1'b1;
    step();
    bus.commit_i = 1'b0;
  endtask

  // Raise vsync, wait out the swap and any copy-back; count frame_swap pulses seen.
  task automatic frame(output int pulses);
    pulses = 0;
    bus.vsync_i = 1'b1;
    step();
    if (bus.frame_swap_o) pulses++;
    step();
    if (bus.frame_swap_o) pulses++;
    bus.vsync_i = 1'b0;
    for (int i = 0; i < 20; i++) begin
      step();
      if (bus.frame_swap_o) pulses++;
    end
  endtask

  task automatic read_all(input string tag, input int exp_const, input bit use_const);
    for (int i = 0; i < 16; i++) begin
      bus.rd_addr_i = 4'(i);
      step();
      if (use_const) chk(tag, int'(bus.rd_data_o), exp_const);
    end
    bus.rd_addr_i = 4'd0;
  endtask

  initial begin
    int pulses, n, seen;
    idle_inputs();
    model_clear();

    // Reset state and all-zero table.
    do_reset();
    read_all("reset_read", 0, 1'b1);

    // Write addr 3, read before commit, then commit and frame.
    write(3, 5'h1A, 1'b0);
    bus.rd_addr_i = 4'd3;
    step();
    chk("pre_commit_rd3", int'(bus.rd_data_o), DBUF ? 0 : 5'h1A);
    commit();
    frame(pulses);
    chk("swap_pulses", pulses, 1);
    bus.rd_addr_i = 4'd3;
    step();
    chk("post_swap_rd3", int'(bus.rd_data_o), 5'h1A);

    // Long pending window with the host hammering writes.
    commit();
    bus.wr_valid_i = 1'b1;
    bus.wr_addr_i  = 4'd9;
    bus.wr_data_i  = 5'h0C;
    for (int i = 0; i < 100; i++) step();
    bus.wr_valid_i = 1'b0;
    bus.vsync_i    = 1'b1;
    seen = 0;
    for (int i = 0; i < 10 && !seen; i++) begin
      step();
      if (bus.frame_swap_o) seen = 1;
    end
    chk("swap_seen", seen, 1);
    bus.vsync_i = 1'b0;
    n = 0;
    while (!bus.wr_ready_o && n < 40) begin
      step();
      n++;
    end
    chk("swap_to_ready_cycles", n, COPY_CYC);
    bus.rd_addr_i = 4'd9;
    step();
    chk("pending_write_dropped", int'(bus.rd_data_o), DBUF ? 0 : 5'h0C);

    // Write together with commit, then a second edit of the same entry.
    write(7, 5'h05, 1'b1);
    frame(pulses);
    bus.rd_addr_i = 4'd7;
    step();
    chk("same_cycle_commit_rd7", int'(bus.rd_data_o), 5'h05);
    write(7, 5'h1F, 1'b0);
    commit();
    frame(pulses);
    read_all("", 0, 1'b0);
    bus.rd_addr_i = 4'd7;
    step();
    chk("second_edit_rd7", int'(bus.rd_data_o), 5'h1F);

    // Asynchronous reset in the middle of the copy-back (or of a pending commit).
    write(2, 5'h13, 1'b1);
    bus.vsync_i = 1'b1;
    seen = 0;
    for (int i = 0; i < 10 && !seen; i++) begin
      step();
      if (bus.frame_swap_o) seen = 1;
    end
    chk("swap_before_reset", seen, 1);
    bus.vsync_i = 1'b0;
    for (int i = 0; i < 8; i++) step();
    if (!DBUF) commit();
    #2;
    rst = 1'b1;
    #1;
    chk("async_rd_data", int'(bus.rd_data_o), 0);
    chk("async_wr_ready", int'(bus.wr_ready_o), 1);
    chk("async_busy", int'(bus.busy_o), 0);
    chk("async_frame_swap", int'(bus.frame_swap_o), 0);
    do_reset();
    read_all("after_reset_front", 0, 1'b1);
    commit();
    frame(pulses);
    read_all("after_reset_back", 0, 1'b1);

    // Random traffic against the model.
    for (int i = 0; i < 3000; i++) begin
      bus.rd_addr_i  = 4'($urandom_range(0, 15));
      bus.wr_valid_i = 1'($urandom_range(0, 1));
      bus.wr_addr_i  = 4'($urandom_range(0, 15));
      bus.wr_data_i  = 5'($urandom_range(0, 31));
      bus.commit_i   = ($urandom_range(0, 15) == 0);
      if ($urandom_range(0, 7) == 0) bus.vsync_i = ~bus.vsync_i;
      step();
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
